// File: rtl/traffic_disp_pkg.sv
// Shared constants for the traffic-light display driver: state codes, glyph ROM and
// 7-segment decode table.
package traffic_disp_pkg;

  localparam logic [1:0] ST_WALK  = 2'd0;
  localparam logic [1:0] ST_STOP  = 2'd1;
  localparam logic [1:0] ST_STAND = 2'd2;
  localparam logic [1:0] ST_DARK  = 2'd3;

  // Index 0 is the pattern for hex digit 0; active-low, bit order gfedcba.
  localparam logic [15:0][6:0] SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h58, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Counter width that also covers the degenerate single-value case.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Glyph ROM: row 0 sits in the top byte of each 64-bit pattern.
  function automatic logic [7:0] glyph_row(input logic [1:0] st, input logic [2:0] row);
    logic [63:0] g;
    g = '0;
    unique case (st)
      ST_WALK:  g = 64'h0C0C_197E_9818_2848;
      ST_STOP:  g = 64'h0024_3CBD_FF3C_3C00;
      ST_STAND: g = 64'h1818_3C3C_5A18_1824;
      ST_DARK:  g = 64'h0000_0000_0000_0000;
    endcase
    return g[8*(7-int'(row)) +: 8];
  endfunction

endpackage

// File: rtl/traffic_display_ctrl_if.sv
// Bundle between the traffic FSM side (master) and the display driver (slave).
interface traffic_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 2
);
  logic [1:0]              state;
  logic [4*NUM_DIGITS-1:0] count_down;
  logic                    lz_blank;
  logic                    blink_en;
  logic [7:0]              dot_row;
  logic [7:0]              dot_col;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_start;

  modport master (
    output state, count_down, lz_blank, blink_en,
    input  dot_row, dot_col, seg, digit_sel, frame_start
  );

  modport slave (
    input  state, count_down, lz_blank, blink_en,
    output dot_row, dot_col, seg, digit_sel, frame_start
  );
endinterface

// File: rtl/disp_scan_timer.sv
// Scan timebase: prescaler, row and digit scan counters, and the frame-rate blink phase.
module disp_scan_timer
  import traffic_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4096,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  output logic                             tick_o,
  output logic                             frame_boundary_o,
  output logic [2:0]                       row_cnt_o,
  output logic [cnt_w(NUM_DIGITS)-1:0]     dig_cnt_o,
  output logic                             blink_phase_o
);

  localparam int unsigned PreW = cnt_w(SCAN_DIV);
  localparam int unsigned DigW = cnt_w(NUM_DIGITS);
  localparam int unsigned BlkW = cnt_w(BLINK_FRAMES);
  localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
  localparam logic [DigW-1:0] DigMax = DigW'(NUM_DIGITS - 1);
  localparam logic [BlkW-1:0] BlkMax = BlkW'(BLINK_FRAMES - 1);

  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]      row_cnt_q, row_cnt_d;
  logic [DigW-1:0] dig_cnt_q, dig_cnt_d;
  logic [BlkW-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic            tick, frame_boundary;

  always_comb begin
    tick           = (pre_cnt_q == PreMax);
    frame_boundary = tick && (row_cnt_q == 3'd7);
    pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
    row_cnt_d      = tick ? row_cnt_q + 3'd1 : row_cnt_q;
    dig_cnt_d      = dig_cnt_q;
    if (tick) begin
      dig_cnt_d = (dig_cnt_q == DigMax) ? '0 : dig_cnt_q + 1'b1;
    end
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_boundary) begin
      if (blink_cnt_q == BlkMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q     <= '0;
      row_cnt_q     <= '0;
      dig_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      row_cnt_q     <= row_cnt_d;
      dig_cnt_q     <= dig_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign tick_o           = tick;
  assign frame_boundary_o = frame_boundary;
  assign row_cnt_o        = row_cnt_q;
  assign dig_cnt_o        = dig_cnt_q;
  assign blink_phase_o    = blink_phase_q;

endmodule

// File: rtl/traffic_display_ctrl.sv
// Traffic-light display driver: scans an 8x8 glyph and a multiplexed 7-segment countdown,
// switching glyphs only on frame boundaries.
module traffic_display_ctrl
  import traffic_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4096,
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter int unsigned BLINK_THRESH = 3
) (
  input logic                   clk,
  input logic                   rst,
  traffic_display_ctrl_if.slave disp_io
);

  localparam int unsigned DigW = cnt_w(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] DigOne = 1;

  logic            tick, frame_boundary, blink_phase;
  logic [2:0]      row_cnt;
  logic [DigW-1:0] dig_cnt;

  disp_scan_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .NUM_DIGITS   (NUM_DIGITS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_scan_timer (
    .clk_i            (clk),
    .rst_i            (rst),
    .tick_o           (tick),
    .frame_boundary_o (frame_boundary),
    .row_cnt_o        (row_cnt),
    .dig_cnt_o        (dig_cnt),
    .blink_phase_o    (blink_phase)
  );

  logic [1:0]              state_q, state_d;
  logic                    row_adv_q;
  logic [7:0]              dot_row_q, dot_row_d, dot_col_q, dot_col_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_start_q, frame_start_d;
  logic                    blank_glyph;
  logic [3:0]              nibble;
  logic [4*NUM_DIGITS-1:0] upper;

  always_comb begin
    state_d       = frame_boundary ? disp_io.state : state_q;
    blank_glyph   = disp_io.blink_en && !blink_phase &&
                    (32'(disp_io.count_down) <= BLINK_THRESH);
    nibble        = disp_io.count_down[4*dig_cnt +: 4];
    upper         = disp_io.count_down >> (4*dig_cnt);
    dot_row_d     = ~(8'h80 >> row_cnt);
    dot_col_d     = blank_glyph ? 8'h00 : glyph_row(state_q, row_cnt);
    digit_sel_d   = ~(DigOne << dig_cnt);
    seg_d         = SEG7[nibble];
    if (disp_io.lz_blank && (dig_cnt != '0) && (upper == '0)) begin
      seg_d = 7'h7F;
    end
    // row_adv_q marks that the counter just stepped, so row 0 here is a fresh frame.
    frame_start_d = row_adv_q && (row_cnt == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_DARK;
      row_adv_q     <= 1'b0;
      dot_row_q     <= 8'hFF;
      dot_col_q     <= 8'h00;
      seg_q         <= 7'h7F;
      digit_sel_q   <= '1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_adv_q     <= tick;
      dot_row_q     <= dot_row_d;
      dot_col_q     <= dot_col_d;
      seg_q         <= seg_d;
      digit_sel_q   <= digit_sel_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign disp_io.dot_row     = dot_row_q;
  assign disp_io.dot_col     = dot_col_q;
  assign disp_io.seg         = seg_q;
  assign disp_io.digit_sel   = digit_sel_q;
  assign disp_io.frame_start = frame_start_q;

endmodule

// File: tb/tb_traffic_display_ctrl.sv
// Directed bench for traffic_display_ctrl: vector table plus hand-written multi-cycle cases.
module tb_traffic_display_ctrl;
  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned NUM_DIGITS   = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned BLINK_THRESH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_display_ctrl_if #(.NUM_DIGITS(NUM_DIGITS)) dif ();

  traffic_display_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .NUM_DIGITS   (NUM_DIGITS),
    .BLINK_FRAMES (BLINK_FRAMES),
    .BLINK_THRESH (BLINK_THRESH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_io (dif.slave)
  );

  typedef struct {
    logic [1:0] st;
    logic [7:0] cd;
    logic       lz;
    logic       bl;
    int         n;
    logic [7:0] row;
    logic [7:0] col;
    logic [6:0] seg;
    logic [1:0] dsel;
    logic       fs;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cur_n    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [7:0] row, input logic [7:0] col,
                           input logic [6:0] seg, input logic [1:0] dsel, input logic fs);
    check({tag, ".dot_row"}, 32'(dif.dot_row), 32'(row));
    check({tag, ".dot_col"}, 32'(dif.dot_col), 32'(col));
    check({tag, ".seg"}, 32'(dif.seg), 32'(seg));
    check({tag, ".digit_sel"}, 32'(dif.digit_sel), 32'(dsel));
    check({tag, ".frame_start"}, 32'(dif.frame_start), 32'(fs));
  endtask

  task automatic set_in(input logic [1:0] st, input logic [7:0] cd, input logic lz,
                        input logic bl);
    dif.state      = st;
    dif.count_down = cd;
    dif.lz_blank   = lz;
    dif.blink_en   = bl;
  endtask

  // Leaves the bench at the falling edge after the last reset edge (output cycle 0).
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_n = 0;
  endtask

  task automatic step_to(input int n);
    while (cur_n < n) begin
      @(negedge clk);
      cur_n++;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] st, input logic [7:0] cd, input logic lz,
                              input logic bl, input int n, input logic [7:0] row,
                              input logic [7:0] col, input logic [6:0] seg,
                              input logic [1:0] dsel, input logic fs);
    vec_t v;
    v = '{st: st, cd: cd, lz: lz, bl: bl, n: n, row: row, col: col, seg: seg,
          dsel: dsel, fs: fs};
    return v;
  endfunction

  logic [7:0] row_codes [8];
  int pulses, first_pulse;

  initial begin
    row_codes = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    // walk / stop / stand / dark glyph, digit scan
    vecs.push_back(mk(0, 8'h25, 0, 0,  1, 8'h7F, 8'h00, 7'h12, 2'b10, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0,  5, 8'hBF, 8'h00, 7'h24, 2'b01, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0, 29, 8'hFE, 8'h00, 7'h24, 2'b01, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0, 33, 8'h7F, 8'h0C, 7'h12, 2'b10, 1));
    vecs.push_back(mk(0, 8'h25, 0, 0, 34, 8'h7F, 8'h0C, 7'h12, 2'b10, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0, 45, 8'hEF, 8'h7E, 7'h24, 2'b01, 0));
    vecs.push_back(mk(0, 8'h25, 0, 0, 61, 8'hFE, 8'h48, 7'h24, 2'b01, 0));
    vecs.push_back(mk(1, 8'h25, 0, 0, 49, 8'hF7, 8'hFF, 7'h12, 2'b10, 0));
    vecs.push_back(mk(1, 8'h25, 0, 0, 57, 8'hFD, 8'h3C, 7'h12, 2'b10, 0));
    vecs.push_back(mk(2, 8'h25, 0, 0, 41, 8'hDF, 8'h3C, 7'h12, 2'b10, 0));
    vecs.push_back(mk(3, 8'h25, 0, 0, 37, 8'hBF, 8'h00, 7'h24, 2'b01, 0));
    // leading-zero blanking
    vecs.push_back(mk(0, 8'h07, 1, 0,  1, 8'h7F, 8'h00, 7'h58, 2'b10, 0));
    vecs.push_back(mk(0, 8'h07, 1, 0,  5, 8'hBF, 8'h00, 7'h7F, 2'b01, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  1, 8'h7F, 8'h00, 7'h40, 2'b10, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0,  5, 8'hBF, 8'h00, 7'h7F, 2'b01, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0,  5, 8'hBF, 8'h00, 7'h40, 2'b01, 0));
    vecs.push_back(mk(0, 8'h70, 1, 0,  1, 8'h7F, 8'h00, 7'h40, 2'b10, 0));
    vecs.push_back(mk(0, 8'h70, 1, 0,  5, 8'hBF, 8'h00, 7'h58, 2'b01, 0));
    vecs.push_back(mk(0, 8'hA0, 0, 0,  5, 8'hBF, 8'h00, 7'h08, 2'b01, 0));
    // end-of-phase blinking, two frames per half-period
    vecs.push_back(mk(2, 8'h03, 0, 1,  33, 8'h7F, 8'h18, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h03, 0, 1,  65, 8'h7F, 8'h00, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h03, 0, 1,  97, 8'h7F, 8'h00, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h03, 0, 1, 129, 8'h7F, 8'h18, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h04, 0, 1,  65, 8'h7F, 8'h18, 7'h19, 2'b10, 1));
    vecs.push_back(mk(2, 8'h03, 0, 0,  65, 8'h7F, 8'h18, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h13, 0, 1,  65, 8'h7F, 8'h18, 7'h30, 2'b10, 1));
    vecs.push_back(mk(2, 8'h03, 1, 1,  77, 8'hEF, 8'h00, 7'h7F, 2'b01, 0));

    // Reset values, then the dark first frame stepping through all rows.
    set_in(0, 8'h25, 0, 0);
    do_reset(3);
    check_all("reset", 8'hFF, 8'h00, 7'h7F, 2'b11, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step_to(4*i + 1);
      check($sformatf("scan%0d.dot_row", i), 32'(dif.dot_row), 32'(row_codes[i]));
      check($sformatf("scan%0d.dot_col", i), 32'(dif.dot_col), 32'h00);
    end

    foreach (vecs[i]) begin
      set_in(vecs[i].st, vecs[i].cd, vecs[i].lz, vecs[i].bl);
      do_reset(2);
      step_to(vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].seg,
                vecs[i].dsel, vecs[i].fs);
    end

    // frame_start: one single-cycle pulse per 32-cycle frame, none right after reset.
    set_in(0, 8'h25, 0, 0);
    do_reset(2);
    pulses = 0;
    first_pulse = -1;
    for (int n = 1; n <= 96; n++) begin
      step_to(n);
      if (dif.frame_start === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = n;
      end
    end
    check("fs_count", 32'(pulses), 32'd2);
    check("fs_first", 32'(first_pulse), 32'd33);

    // State change mid-frame only takes effect at the next frame.
    set_in(0, 8'h25, 0, 0);
    do_reset(2);
    step_to(45);
    dif.state = 2'd1;
    step_to(53); check("midstate.r5", 32'(dif.dot_col), 32'h18);
    step_to(61); check("midstate.r7", 32'(dif.dot_col), 32'h48);
    step_to(65); check("midstate.n0", 32'(dif.dot_col), 32'h00);
    step_to(69); check("midstate.n1", 32'(dif.dot_col), 32'h24);
    step_to(77); check("midstate.n3", 32'(dif.dot_col), 32'hBD);

    // count_down is not shadowed.
    set_in(0, 8'h25, 0, 0);
    do_reset(2);
    step_to(2); check("cdchg.before", 32'(dif.seg), 32'h12);
    dif.count_down = 8'h38;
    step_to(3); check("cdchg.after", 32'(dif.seg), 32'h00);
    step_to(5); check("cdchg.dig1", 32'(dif.seg), 32'h30);

    // Reset in the middle of a frame.
    set_in(0, 8'h25, 0, 0);
    do_reset(2);
    step_to(53);
    rst = 1'b1;
    @(negedge clk);
    check_all("midrst", 8'hFF, 8'h00, 7'h7F, 2'b11, 1'b0);
    rst = 1'b0;
    cur_n = 0;
    pulses = 0;
    for (int n = 1; n <= 32; n++) begin
      step_to(n);
      if (dif.frame_start === 1'b1) pulses++;
      if (n == 21) check("midrst.dark", 32'(dif.dot_col), 32'h00);
    end
    check("midrst.fs_none", 32'(pulses), 32'd0);
    step_to(33);
    check("midrst.fs2", 32'(dif.frame_start), 32'd1);
    check("midrst.walk", 32'(dif.dot_col), 32'h0C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
